// File: rtl/fpcvt_pkg.sv
// Widths and FSM state encoding shared by the linear<->float converters.
// Both the encoder and fp_decode import this package.
package fpcvt_pkg;
    localparam int LIN_W = 12;
    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam logic [LIN_W-1:0] MAG_MAX = 12'h780;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } fpdec_state_t;
endpackage

// File: rtl/fpdec_shift.sv
// Combinational barrel shifter: magnitude = F << E, zero-extended to LIN_W.
// Used by fp_decode only when FPDEC_BARREL_EN is defined.
module fpdec_shift
    import fpcvt_pkg::*;
(
    input  logic [MAN_W-1:0] f,
    input  logic [EXP_W-1:0] e,
    output logic [LIN_W-1:0] mag
);
    assign mag = {{(LIN_W-MAN_W){1'b0}}, f} << e;
endmodule

// File: rtl/fp_decode.sv
// Decodes an 8-bit float (S,E[2:0],F[3:0]) to a 12-bit two's-complement value, D = +/-(F<<E).
// Iterative shift (latency E+2), or a one-cycle barrel shift when FPDEC_BARREL_EN is defined.
module fp_decode
    import fpcvt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S,
    input  logic [EXP_W-1:0] E,
    input  logic [MAN_W-1:0] F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LIN_W-1:0] D,
    output logic             nonorm
);
    fpdec_state_t     state_q, state_d;
    logic             sgn_q, sgn_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic [LIN_W-1:0] mag_q, mag_d;
    logic             nf_q, nf_d;
    logic [LIN_W-1:0] d_q, d_d;
    logic             nonorm_q, nonorm_d;

`ifdef FPDEC_BARREL_EN
    logic [LIN_W-1:0] shift_mag;

    // mag_q[3:0] still holds the captured mantissa while in SHIFT
    fpdec_shift u_shift (
        .f   (mag_q[MAN_W-1:0]),
        .e   (cnt_q),
        .mag (shift_mag)
    );
`endif

    always_comb begin
        state_d  = state_q;
        sgn_d    = sgn_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        nf_d     = nf_q;
        d_d      = d_q;
        nonorm_d = nonorm_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sgn_d   = S;
                    cnt_d   = E;
                    mag_d   = {{(LIN_W-MAN_W){1'b0}}, F};
                    nf_d    = (E != '0) && !F[MAN_W-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
`ifdef FPDEC_BARREL_EN
                mag_d   = shift_mag;
                cnt_d   = '0;
                state_d = NEGATE;
`else
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = NEGATE;
                end
`endif
            end
            NEGATE: begin
                d_d      = sgn_q ? (~mag_q + 1'b1) : mag_q;
                nonorm_d = nf_q;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sgn_q    <= 1'b0;
            cnt_q    <= '0;
            mag_q    <= '0;
            nf_q     <= 1'b0;
            d_q      <= '0;
            nonorm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sgn_q    <= sgn_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            nf_q     <= nf_d;
            d_q      <= d_d;
            nonorm_q <= nonorm_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign D         = d_q;
    assign nonorm    = nonorm_q;
endmodule

// File: tb/tb_fp_decode.sv
// Directed bench for fp_decode: values, nonorm flag, latency, backpressure, async reset.
module tb_fp_decode;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        S = 1'b0;
    logic [2:0]  E = 3'd0;
    logic [3:0]  F = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] D;
    logic        nonorm;

    int checks = 0;
    int errors = 0;

    fp_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .nonorm    (nonorm)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [2:0] e);
`ifdef FPDEC_BARREL_EN
        return 2;
`else
        return int'(e) + 2;
`endif
    endfunction

    // Presents one code, waits for the accept edge, then counts edges until out_valid.
    task automatic decode(input logic s, input logic [2:0] e, input logic [3:0] f, output int lat);
        S = s; E = e; F = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; S = 1'b0; E = 3'd0; F = 4'd0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (D !== 12'h000) begin errors++; $display("FAIL reset_D got %h want 000", D); end
        checks++; if (nonorm !== 1'b0) begin errors++; $display("FAIL reset_nonorm got %b want 0", nonorm); end
    endtask

    task automatic test_value(input string name, input logic s, input logic [2:0] e,
                              input logic [3:0] f, input logic [11:0] exp_d, input logic exp_nf);
        int lat;
        decode(s, e, f, lat);
        checks++; if (lat != exp_lat(e)) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat(e)); end
        checks++; if (D !== exp_d) begin errors++; $display("FAIL %s_D got %h want %h", name, D, exp_d); end
        checks++; if (nonorm !== exp_nf) begin errors++; $display("FAIL %s_nonorm got %b want %b", name, nonorm, exp_nf); end
        release_result();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_handoff in_ready %b out_valid %b want 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_values();
        test_value("e0_f13", 1'b0, 3'd0, 4'hD, 12'h00D, 1'b0);
        test_value("max",    1'b0, 3'd7, 4'hF, 12'h780, 1'b0);
        test_value("neg80",  1'b1, 3'd3, 4'hA, 12'hFB0, 1'b0);
        test_value("negzero",1'b1, 3'd0, 4'h0, 12'h000, 1'b0);
        test_value("nonorm", 1'b0, 3'd2, 4'h5, 12'h014, 1'b1);
    endtask

    task automatic test_backpressure();
        int lat;
        decode(1'b0, 3'd1, 4'h8, lat);
        checks++; if (lat != exp_lat(3'd1)) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, exp_lat(3'd1)); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2); S = 1'b1; E = 3'd5; F = 4'hC;
            @(posedge clk); #1;
            checks++; if (D !== 12'h010 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold_%0d D %h out_valid %b want 010 1", i, D, out_valid);
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0; S = 1'b0; E = 3'd0; F = 4'd0;
        release_result();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || D !== 12'h010) begin
            errors++; $display("FAIL bp_ignored_pulse in_ready %b D %h want 1 010", in_ready, D);
        end
    endtask

    task automatic test_reset_midop();
        S = 1'b1; E = 3'd7; F = 4'hF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midop_busy in_ready got %b want 0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midop_reset_hs out_valid %b in_ready %b want 0 1", out_valid, in_ready);
        end
        checks++; if (D !== 12'h000 || nonorm !== 1'b0) begin
            errors++; $display("FAIL midop_reset_data D %h nonorm %b want 000 0", D, nonorm);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_value("post_reset", 1'b1, 3'd2, 4'hC, 12'hFD0, 1'b0);
    endtask

    initial begin
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_values();
        test_backpressure();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_decode.md
# fp_decode

Sequential decoder from the 8-bit floating-point format (sign S, 3-bit exponent E, 4-bit mantissa F) back to a 12-bit two's-complement linear value. It is the inverse of the linear-to-float converter. The decoded magnitude is F << E, negated when S=1. The block has a valid/ready handshake on both sides and sits between a float source (register file, switches, or a serial receiver) and linear-domain consumers (display, accumulator).

## Interface
- No parameters. Widths are fixed by the shared package.
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  S/E/F hold a code to decode.
- in_ready  out  1  block can accept a code. High only in IDLE.
- S  in  1  sign bit (1 = negative).
- E  in  3  exponent, 0..7.
- F  in  4  mantissa, 0..15.
- out_valid  out  1  D and nonorm hold a result.
- out_ready  in  1  consumer takes the result.
- D  out  12  two's-complement result.
- nonorm  out  1  the input code was not normalized (E≠0 and F[3]=0).

## Operation
- FSM states are IDLE, SHIFT, NEGATE and DONE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: capture sgn←S, cnt←E, mag←{8'b0,F}, nf←(E≠0 && F[3]==0). Go to SHIFT.
- SHIFT
  - If cnt≠0: mag←mag<<1 and cnt←cnt−1. Stay in SHIFT.
  - If cnt==0: go to NEGATE.
- NEGATE
  - If sgn: D←~mag+1. Otherwise D←mag.
  - nonorm←nf. Go to DONE.
- DONE
  - out_valid=1. D and nonorm are held stable.
  - On out_ready: go to IDLE.
- Arithmetic
  - mag is 12 bits wide. The maximum magnitude is 15<<7 = 1920 (0x780), so mag never reaches bit 11 and there is no overflow.
  - S=1 with magnitude 0 yields D=0x000.
- Non-normalized codes are decoded literally (F<<E) and flagged. They are never rejected.
- Inputs are ignored outside IDLE. in_valid must be held by the source until accepted.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, D=12'h000, nonorm=0, and all internal registers are 0.
- Reset mid-operation (any state) aborts immediately and asynchronously. The in-flight code is discarded with no partial output.
- Latency:
  - The accept edge is edge 0.
  - out_valid rises after edge E+2 (iterative build).
  - Range is 2 cycles (E=0) to 9 cycles (E=7).
- Throughput: one code per E+3 cycles minimum. There is no bypass, so in_ready rises the cycle after the DONE→IDLE edge.
- out_ready asserted while not in DONE has no effect.
- Backpressure: DONE is held indefinitely while out_ready=0.
- D and nonorm change only on the NEGATE→DONE edge and on reset.

## Configuration
- FPDEC_BARREL_EN
  - Defined: SHIFT lasts exactly one cycle and computes mag←{8'b0,F}<<E with a combinational barrel shifter. Latency is a constant 2 cycles; throughput is one per 3 cycles.
  - Undefined: the iterative one-bit-per-cycle shift described above. Latency is E+2.
- Results (D, nonorm) are bit-identical in both builds. Only the timing differs.

## Structure
- Shared package fpcvt_pkg, used by both the converter and this decoder:
  - width constants LIN_W=12, EXP_W=3, MAN_W=4, MAG_MAX=12'h780;
  - state enum typedef fpdec_state_t {IDLE, SHIFT, NEGATE, DONE}.
- One sub-module, fpdec_shift: a combinational barrel shifter taking F[3:0] and E[2:0] and producing a 12-bit magnitude. It is instantiated only under FPDEC_BARREL_EN.

## Test plan
- S=0, E=000, F=1101: D=12'h00D, nonorm=0. out_valid 2 cycles after accept.
- S=0, E=111, F=1111: D=12'h780 (1920). out_valid 9 cycles after accept (2 with FPDEC_BARREL_EN).
- S=1, E=011, F=1010: magnitude 80, D=12'hFB0 (−80), nonorm=0. Also S=1, E=000, F=0000: D=12'h000.
- S=0, E=010, F=0101: D=12'h014 (20), nonorm=1.
- Backpressure with S=0, E=001, F=1000:
  - hold out_ready=0 for 5 cycles in DONE;
  - D=12'h010 stays stable, in_ready stays 0, and a new in_valid pulse is ignored;
  - raise out_ready: in_ready=1 on the next cycle.
- Reset mid-operation: accept S=1, E=111, then pull rst_n low during SHIFT. Required immediately: out_valid=0, in_ready=1, D=12'h000, nonorm=0. After release, a fresh decode completes correctly.
